// File: rtl/motor_modulation_ctrl.sv
// Mode-to-duty sequencer for the two wheel motors: debounces the tracker mode,
// kick-starts out of stop, then slew-limits each wheel toward its per-mode target.
module motor_modulation_ctrl #(
    parameter int unsigned TICK_DIV      = 100000,
    parameter int unsigned STEP          = 16,
    parameter int unsigned KICK_TICKS    = 20,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] mode,
    output logic [9:0] modulation_left,
    output logic [9:0] modulation_right,
    output logic       moving,
    output logic       settled
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned KW = $clog2(KICK_TICKS + 1);
    localparam int unsigned DW = $clog2(STABLE_CYCLES + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [KW-1:0] KICK_LOAD = KW'(KICK_TICKS);
    localparam logic [DW-1:0] STABLE_N  = DW'(STABLE_CYCLES);
    localparam logic [9:0]    STEP_W    = 10'(STEP);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_KICK,
        ST_RAMP,
        ST_HOLD
    } state_t;

    function automatic logic is_stop(input logic [2:0] m);
        return (m == 3'b011) || (m[2:1] == 2'b11);
    endfunction

    // Packed as {left, right}.
    function automatic logic [19:0] target_of(input logic [2:0] m);
        case (m)
            3'b000:  return {10'd768,  10'd1023};
            3'b001:  return {10'd1023, 10'd768};
            3'b010:  return {10'd1023, 10'd1023};
            3'b100:  return {10'd512,  10'd1023};
            3'b101:  return {10'd1023, 10'd512};
            default: return {10'd0,    10'd0};
        endcase
    endfunction

    function automatic logic [9:0] ramp_step(input logic [9:0] cur, input logic [9:0] tgt);
        logic signed [10:0] diff;
        logic signed [11:0] nxt;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > $signed({1'b0, STEP_W}))
            nxt = $signed({2'b00, cur}) + $signed({2'b00, STEP_W});
        else if (diff < -$signed({1'b0, STEP_W}))
            nxt = $signed({2'b00, cur}) - $signed({2'b00, STEP_W});
        else
            nxt = $signed({2'b00, tgt});
        if (nxt < 12'sd0)
            return '0;
        else if (nxt > 12'sd1023)
            return '1;
        else
            return nxt[9:0];
    endfunction

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [2:0]    cand_q, cand_d;
    logic [2:0]    acc_q, acc_d;
    logic [KW-1:0] kick_q, kick_d;
    logic [9:0]    left_q, left_d;
    logic [9:0]    right_q, right_d;
    logic          moving_q, moving_d;
    logic          settled_q, settled_d;

    logic          tick;
    logic [9:0]    tgt_l, tgt_r;
    logic [9:0]    nxt_tgt_l, nxt_tgt_r;

    always_comb begin
        tick   = (tick_q == TICK_LAST);
        tick_d = tick ? '0 : tick_q + TW'(1);

        cand_d = mode;
        if (mode != cand_q)
            deb_d = DW'(1);
        else if (deb_q != STABLE_N)
            deb_d = deb_q + DW'(1);
        else
            deb_d = deb_q;
        acc_d = (deb_d == STABLE_N) ? mode : acc_q;

        {tgt_l, tgt_r} = target_of(acc_q);

        state_d = state_q;
        left_d  = left_q;
        right_d = right_q;
        kick_d  = kick_q;

        case (state_q)
            ST_STOP: begin
                left_d  = '0;
                right_d = '0;
                if (enable && !is_stop(acc_q)) begin
                    state_d = ST_KICK;
                    left_d  = '1;
                    right_d = '1;
                    kick_d  = KICK_LOAD;
                end
            end
            ST_KICK: begin
                left_d  = '1;
                right_d = '1;
                if (tick) begin
                    kick_d = kick_q - KW'(1);
                    if (kick_q == KW'(1))
                        state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (left_q == tgt_l && right_q == tgt_r) begin
                    state_d = ST_HOLD;
                end else if (tick) begin
                    left_d  = ramp_step(left_q, tgt_l);
                    right_d = ramp_step(right_q, tgt_r);
                    if (left_d == tgt_l && right_d == tgt_r)
                        state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (left_q != tgt_l || right_q != tgt_r)
                    state_d = ST_RAMP;
            end
            default: state_d = ST_STOP;
        endcase

        // Stop always wins and is applied without ramping.
        if (state_q != ST_STOP && (!enable || is_stop(acc_q))) begin
            state_d = ST_STOP;
            left_d  = '0;
            right_d = '0;
        end

        // Judged against the mode accepted on this same edge so the flag tracks the outputs.
        {nxt_tgt_l, nxt_tgt_r} = target_of(acc_d);
        settled_d = (left_d == nxt_tgt_l) && (right_d == nxt_tgt_r) && (state_d != ST_KICK);
        moving_d  = (state_d != ST_STOP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_STOP;
            tick_q    <= '0;
            deb_q     <= '0;
            cand_q    <= 3'b011;
            acc_q     <= 3'b011;
            kick_q    <= '0;
            left_q    <= '0;
            right_q   <= '0;
            moving_q  <= 1'b0;
            settled_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            deb_q     <= deb_d;
            cand_q    <= cand_d;
            acc_q     <= acc_d;
            kick_q    <= kick_d;
            left_q    <= left_d;
            right_q   <= right_d;
            moving_q  <= moving_d;
            settled_q <= settled_d;
        end
    end

    assign modulation_left  = left_q;
    assign modulation_right = right_q;
    assign moving           = moving_q;
    assign settled          = settled_q;

endmodule

// File: doc/motor_modulation_ctrl.md
# motor_modulation_ctrl

Sequencing controller that turns the line-tracker's 3-bit driving mode into the per-wheel 10-bit duty words (`modulation_left` / `modulation_right`) consumed by `motor`. It debounces mode changes and applies a full-power kick-start when leaving stop. It then slew-limits each wheel's duty toward the per-mode target, and forces an immediate stop on stop-mode or disable. It sits between the tracker/decision logic and `motor`, replacing direct constant-duty assignment.

## Interface
- `TICK_DIV`, 100000: clk cycles per ramp tick (1 ms at 100 MHz); must be ≥ 1.
- `STEP`, 16: max duty change per wheel per tick, range 1..1023.
- `KICK_TICKS`, 20: ticks of 1023/1023 kick-start after leaving STOP; must be ≥ 1.
- `STABLE_CYCLES`, 4: consecutive clk cycles raw mode must hold before acceptance; must be ≥ 1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  run permission; low forces STOP.
- `mode`  in  3  raw mode: 000 turn_left, 001 turn_right, 010 go_straight, 011 stop, 100 sharp_left, 101 sharp_right, 110/111 treated as stop.
- `modulation_left`  out  10  left duty word to `motor`.
- `modulation_right`  out  10  right duty word to `motor`.
- `moving`  out  1  high in KICK/RAMP/HOLD.
- `settled`  out  1  high when both outputs equal current targets and state is not KICK.

## Operation
- Targets (left/right): go_straight 1023/1023; turn_left 768/1023; turn_right 1023/768; sharp_left 512/1023; sharp_right 1023/512; stop/invalid 0/0. No non-zero target is below 512.
- Debounce: register `mode` into a candidate. A counter increments while the sample equals the candidate and reloads to 1 on a change. Accepted mode takes the candidate on the edge where the count reaches `STABLE_CYCLES`. Shorter pulses never reach the state machine.
- Tick: free-running counter 0..`TICK_DIV`-1. `tick` is high for one cycle at the terminal count, then the counter wraps to 0.
- State machine:
  - STOP: outputs 0/0. Moves to KICK when `enable`=1 and accepted mode is non-stop. Loads kick counter with `KICK_TICKS`.
  - KICK: outputs 1023/1023. Decrements the kick counter on each tick and goes to RAMP on the tick where it reaches 0.
  - RAMP: on each tick, each wheel moves toward its target by min(`STEP`, |target−out|). Enters HOLD on the edge both equal targets.
  - HOLD: outputs steady. Re-enters RAMP when the accepted mode changes target.
  - Any state other than STOP goes to STOP, with outputs 0/0, on the edge where `enable`=0 or accepted mode is stop/invalid. Stop is never ramped.
- Arithmetic: difference computed in 11-bit signed. Result is clamped to 0..1023, with no wrap.
- A mode change in KICK updates the target only; the kick completes first.

## Timing
- Reset values: `modulation_left`=0, `modulation_right`=0, `moving`=0, `settled`=1, state STOP, accepted mode 011, tick counter 0, debounce counter 0.
- All outputs are registered, with no combinational path from inputs.
- `enable` falling: outputs 0 on the next edge.
- Raw mode change at edge N: accepted at edge N+`STABLE_CYCLES`−1. State and outputs react at edge N+`STABLE_CYCLES`.
- STOP→KICK: outputs become 1023/1023 on the same edge the state enters KICK.
- Kick duration: `KICK_TICKS` ticks, with the first tick counted when it is the first tick after entry.
- Ramp: a change of D takes ceil(D/`STEP`) ticks.
- `settled` is valid on the same edge as the output update.
- Async reset mid-operation clears outputs without a clock edge. After release, restart from STOP.

## Test plan
Parameters: `TICK_DIV`=4, `STEP`=256, `KICK_TICKS`=2, `STABLE_CYCLES`=2.
- Start: reset, `enable`=1, mode 010 → outputs 1023/1023 two edges after mode is applied; KICK for 2 ticks; then HOLD with `settled`=1 and `moving`=1.
- Ramp down: in HOLD straight, mode 100 → left goes 1023→767→512 on successive ticks; right holds 1023; `settled` rises with 512.
- Glitch rejection: in HOLD straight, mode 001 for 1 cycle, then back to 010 → outputs unchanged at 1023/1023.
- Immediate stop: mid-KICK drop `enable` → 0/0 next edge, `moving`=0. Repeat with mode 011 held 2 cycles, and with mode 111.
- Kick then ramp: from STOP, mode 000 → 1023/1023 for 2 ticks; left ramps 1023→768 in 1 tick (step 255); right stays 1023.
- Async reset mid-RAMP → outputs 0/0 immediately without clk; after release, state STOP and `settled`=1.
